// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the core. Show-ahead output, sticky overflow flag.
// Define UART_RX_FIFO_LEVEL_EN to add the registered-state-derived `level` occupancy port.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         in_byte,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_byte,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     full,
    output logic                     overflow,
`ifdef UART_RX_FIFO_LEVEL_EN
    output logic [$clog2(DEPTH):0]   level,
`endif
    input  logic                     overflow_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             empty, push, pop, drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees a slot, so a push is accepted even at full.
    assign pop  = !empty && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (drop)                overflow_d = 1'b1;
        else if (overflow_clear) overflow_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; contents are only meaningful between the pointers.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_byte;
    end

    assign out_byte  = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid = !empty;
    assign overflow  = overflow_q;

`ifdef UART_RX_FIFO_LEVEL_EN
    assign level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, WIDTH=8).
module tb_uart_rx_fifo;

    logic       clock;
    logic       reset_n;
    logic [7:0] in_byte;
    logic       in_valid;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       full;
    logic       overflow;
    logic       overflow_clear;
`ifdef UART_RX_FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_byte        (in_byte),
        .in_valid       (in_valid),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .full           (full),
        .overflow       (overflow),
`ifdef UART_RX_FIFO_LEVEL_EN
        .level          (level),
`endif
        .overflow_clear (overflow_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_byte = '0; in_valid = 1'b0; out_ready = 1'b0; overflow_clear = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`ifdef UART_RX_FIFO_LEVEL_EN
        checks++; if (level !== 5'd0)     begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
`endif
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        in_byte = 8'h35; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_byte !== 8'h35) begin errors++; $display("FAIL single_byte got=%h exp=35", out_byte); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%b exp=0", out_valid); end
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            in_byte = 8'(i); in_valid = 1'b1;
            tick();
            checks++;
            if (full !== (i == 15)) begin errors++; $display("FAIL fill_full idx=%0d got=%b exp=%b", i, full, (i == 15)); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fill_overflow_drain();
        fill16();
`ifdef UART_RX_FIFO_LEVEL_EN
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level got=%0d exp=16", level); end
`endif
        in_byte = 8'hAA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow got=%b exp=1", overflow); end
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL drop_full got=%b exp=1", full); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_byte !== 8'(i)) begin
                errors++; $display("FAIL drain_byte idx=%0d got=%h/%b exp=%h/1", i, out_byte, out_valid, 8'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_push_pop_at_full();
        fill16();
        in_byte = 8'h5A; in_valid = 1'b1; out_ready = 1'b1;
        checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL pp_first_byte got=%h exp=00", out_byte); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL pp_full got=%b exp=1", full); end
    endtask

    task automatic test_overflow_clear();
        // Still full here: a drop together with clear must leave overflow set.
        in_byte = 8'hBB; in_valid = 1'b1; overflow_clear = 1'b1;
        tick();
        in_valid = 1'b0; overflow_clear = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_drain_after_pp();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 16) ? 8'h5A : 8'(i);
            checks++;
            if (out_valid !== 1'b1 || out_byte !== exp_b) begin
                errors++; $display("FAIL pp_drain idx=%0d got=%h/%b exp=%h/1", i, out_byte, out_valid, exp_b);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_drain_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_wrap();
        // Pushes 0x40..0x67; pops start two cycles later, so occupancy stays at 2.
        for (int c = 0; c < 42; c++) begin
            in_valid  = (c < 40);
            in_byte   = 8'(8'h40 + c);
            out_ready = (c >= 2);
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_byte !== 8'(8'h40 + c - 2)) begin
                    errors++; $display("FAIL wrap_byte c=%0d got=%h/%b exp=%h/1", c, out_byte, out_valid, 8'(8'h40 + c - 2));
                end
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%b exp=0", out_valid); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL wrap_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_async_reset();
        fill16();
        in_byte = 8'hCC; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL arst_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL arst_overflow got=%b exp=0", overflow); end
`ifdef UART_RX_FIFO_LEVEL_EN
        checks++; if (level !== 5'd0)     begin errors++; $display("FAIL arst_level got=%0d exp=0", level); end
`endif
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_after got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow_drain();
        test_push_pop_at_full();
        test_overflow_clear();
        test_drain_after_pp();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
